// File: rtl/step_pulse_gen_pkg.sv
// Shared types, rate constants and the MODE-to-rate lookup for step_pulse_gen.
// The hybrid schedule table exists only when STEP_PULSE_GEN_HYBRID_EN is defined.
package step_gen_pkg;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_JOG    = 2'b01,
    MODE_RUN    = 2'b10,
    MODE_HYBRID = 2'b11
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] WALK_RATE        = 8'd32;
  localparam logic [7:0] JOG_RATE         = 8'd64;
  localparam logic [7:0] RUN_RATE         = 8'd128;
  localparam int         HYBRID_LEN       = 9;
  localparam logic [7:0] HYBRID_TAIL_RATE = 8'd69;

`ifdef STEP_PULSE_GEN_HYBRID_EN
  // Entry 0 sits in the least significant byte.
  localparam logic [HYBRID_LEN-1:0][7:0] HYBRID_RATES = {
    8'd33, 8'd30, 8'd19, 8'd30, 8'd70, 8'd27, 8'd66, 8'd33, 8'd20
  };
`endif

  function automatic logic [7:0] mode_rate(input mode_t mode, input logic [15:0] sec);
    logic [7:0] r;
    r = 8'd0;
    case (mode)
      MODE_WALK: r = WALK_RATE;
      MODE_JOG:  r = JOG_RATE;
      MODE_RUN:  r = RUN_RATE;
      MODE_HYBRID: begin
`ifdef STEP_PULSE_GEN_HYBRID_EN
        if (sec < 16'(HYBRID_LEN)) r = HYBRID_RATES[sec[3:0]];
        else                       r = HYBRID_TAIL_RATE;
`else
        r = 8'd0;
`endif
      end
      default: r = 8'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Control/status bundle between the board switches, step_pulse_gen and the tracker.
interface step_pulse_gen_if;
  logic        START;
  logic [1:0]  MODE;
  logic        PULSE;
  logic        STEP_STB;
  logic        SEC_TICK;
  logic [15:0] ELAPSED_SEC;
  logic [7:0]  RATE;

  modport master (
    output START, MODE,
    input  PULSE, STEP_STB, SEC_TICK, ELAPSED_SEC, RATE
  );

  modport slave (
    input  START, MODE,
    output PULSE, STEP_STB, SEC_TICK, ELAPSED_SEC, RATE
  );
endinterface

// File: rtl/step_pulse_gen_rate_accumulator.sv
// Phase accumulator: adds RATE every enabled cycle, strobes on each CLK_HZ crossing,
// and restarts from zero at every one-second boundary.
module rate_accumulator #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sec_end,
  input  logic [7:0] rate,
  output logic       step_stb
);

  localparam int             AW = $clog2(CLK_HZ + 128) + 1;
  localparam logic [AW-1:0]  HZ = AW'(CLK_HZ);

  logic [AW-1:0] acc_reg;
  logic [AW-1:0] sum;
  logic          wrap;
  logic          step_stb_reg;

  always_comb begin
    sum  = acc_reg + AW'(rate);
    wrap = (sum >= HZ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      step_stb_reg <= 1'b0;
    end else if (!en) begin
      acc_reg      <= '0;
      step_stb_reg <= 1'b0;
    end else begin
      step_stb_reg <= wrap;
      // Clearing at the boundary discards rounding residue so each second is exact.
      if (sec_end)   acc_reg <= '0;
      else if (wrap) acc_reg <= sum - HZ;
      else           acc_reg <= sum;
    end
  end

  assign step_stb = step_stb_reg;

endmodule

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: step source for the tracker at walk/jog/run/hybrid rates, exact per second.
// Define STEP_PULSE_GEN_HYBRID_EN to make MODE 11 follow the hybrid schedule (else RATE 0).
module step_pulse_gen
  import step_gen_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int PULSE_W = 4
) (
  input logic             CLK,
  input logic             RESET,
  step_pulse_gen_if.slave bus
);

  localparam int             SCW      = $clog2(CLK_HZ);
  localparam int             PCW      = $clog2(PULSE_W + 1);
  localparam logic [SCW-1:0] SEC_LAST = SCW'(CLK_HZ - 1);

  state_t         state_reg;
  logic [SCW-1:0] sec_cnt_reg;
  logic [7:0]     rate_reg;
  logic [7:0]     rate_now;
  logic [15:0]    elapsed_reg;
  logic           sec_tick_reg;
  logic [PCW-1:0] pulse_cnt_reg;
  logic           load;
  logic           sec_end;
  logic           step_stb;

  // The rate is sampled on the first cycle of each second and used on that same cycle.
  always_comb begin
    load     = bus.START && ((state_reg == IDLE) || (sec_cnt_reg == '0));
    sec_end  = bus.START && (sec_cnt_reg == SEC_LAST);
    rate_now = load ? mode_rate(mode_t'(bus.MODE), elapsed_reg) : rate_reg;
  end

  rate_accumulator #(
    .CLK_HZ(CLK_HZ)
  ) u_acc (
    .clk     (CLK),
    .rst     (RESET),
    .en      (bus.START),
    .sec_end (sec_end),
    .rate    (rate_now),
    .step_stb(step_stb)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= IDLE;
      sec_cnt_reg   <= '0;
      rate_reg      <= '0;
      elapsed_reg   <= '0;
      sec_tick_reg  <= 1'b0;
      pulse_cnt_reg <= '0;
    end else if (!bus.START) begin
      state_reg     <= IDLE;
      sec_cnt_reg   <= '0;
      rate_reg      <= '0;
      elapsed_reg   <= '0;
      sec_tick_reg  <= 1'b0;
      pulse_cnt_reg <= '0;
    end else begin
      state_reg    <= RUN;
      rate_reg     <= rate_now;
      sec_tick_reg <= sec_end;
      if (sec_end) begin
        sec_cnt_reg <= '0;
        if (elapsed_reg != 16'hFFFF) elapsed_reg <= elapsed_reg + 16'd1;
      end else begin
        sec_cnt_reg <= sec_cnt_reg + SCW'(1);
      end
      if (step_stb)                pulse_cnt_reg <= PCW'(PULSE_W);
      else if (pulse_cnt_reg != 0) pulse_cnt_reg <= pulse_cnt_reg - PCW'(1);
    end
  end

  assign bus.PULSE       = (pulse_cnt_reg != '0);
  assign bus.STEP_STB    = step_stb;
  assign bus.SEC_TICK    = sec_tick_reg;
  assign bus.ELAPSED_SEC = elapsed_reg;
  assign bus.RATE        = rate_reg;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen at CLK_HZ=1024, PULSE_W=2 with randomized mode sequences.
module tb_step_pulse_gen;

  localparam int HZ = 1024;
  localparam int PW = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  step_pulse_gen_if bus ();

  step_pulse_gen #(
    .CLK_HZ (HZ),
    .PULSE_W(PW)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int   cyc     = 0;
  logic en_edge = 1'b0;

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    en_edge <= bus.START && !RESET;
  end

  typedef struct {
    int cyc;
    int rate;
    int elapsed;
  } tick_t;

  int    checks = 0;
  int    errors = 0;
  int    stb_q[$];
  tick_t tick_q[$];
  int    seg_mode[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

`ifdef STEP_PULSE_GEN_HYBRID_EN
  int hyb_tab[9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};
`endif

  // Steps per second for a given mode in the s-th second since START rose.
  function automatic int model_rate(input int m, input int s);
    case (m)
      0: return 32;
      1: return 64;
      2: return 128;
      default: begin
`ifdef STEP_PULSE_GEN_HYBRID_EN
        if (s < 9) return hyb_tab[s];
        return 69;
`else
        return 0;
`endif
      end
    endcase
  endfunction

  // Monitor: pops expected events whenever the DUT presents a strobe or tick.
  initial begin
    int    pulse_win;
    bit    low_pending;
    int    e;
    tick_t t;
    pulse_win   = 0;
    low_pending = 0;
    forever begin
      @(negedge CLK);
      if (pulse_win > 0) begin
        if (en_edge) begin
          chk("pulse_high", int'(bus.PULSE), 1);
          pulse_win--;
          if (pulse_win == 0) low_pending = 1;
        end else begin
          chk("pulse_cleared", int'(bus.PULSE), 0);
          pulse_win = 0;
        end
      end else if (low_pending) begin
        chk("pulse_low", int'(bus.PULSE), 0);
        low_pending = 0;
      end
      if (bus.STEP_STB) begin
        if (stb_q.size() == 0) begin
          chk("stb_unexpected", cyc, -1);
        end else begin
          e = stb_q.pop_front();
          chk("stb_cycle", cyc, e);
        end
        pulse_win   = PW;
        low_pending = 0;
      end
      if (bus.SEC_TICK) begin
        if (tick_q.size() == 0) begin
          chk("tick_unexpected", cyc, -1);
        end else begin
          t = tick_q.pop_front();
          chk("tick_cycle", cyc, t.cyc);
          chk("tick_rate", int'(bus.RATE), t.rate);
          chk("tick_elapsed", int'(bus.ELAPSED_SEC), t.elapsed);
        end
      end
    end
  end

  task automatic check_cleared();
    chk("clr_pulse", int'(bus.PULSE), 0);
    chk("clr_stb", int'(bus.STEP_STB), 0);
    chk("clr_tick", int'(bus.SEC_TICK), 0);
    chk("clr_elapsed", int'(bus.ELAPSED_SEC), 0);
    chk("clr_rate", int'(bus.RATE), 0);
  endtask

  // Runs nsec full seconds plus tail cycles with START high, using seg_mode[s] for second s.
  task automatic run_segment(input int nsec, input int tail, input int fixed_off, input bit end_reset);
    int    p0, total, r, k, off;
    tick_t t;
    p0    = cyc;
    total = nsec * HZ + tail;
    for (int s = 0; s * HZ < total; s++) begin
      r = model_rate(seg_mode[s], s);
      for (int j = 1; j <= r; j++) begin
        k = s * HZ + (j * HZ + r - 1) / r;
        if (k <= total) stb_q.push_back(p0 + k);
      end
      if ((s + 1) * HZ <= total) begin
        t.cyc     = p0 + (s + 1) * HZ;
        t.rate    = r;
        t.elapsed = s + 1;
        tick_q.push_back(t);
      end
    end
    off = (fixed_off > 0) ? fixed_off : int'($urandom_range(1, HZ - 2));
    bus.MODE  = 2'(seg_mode[0]);
    bus.START = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(negedge CLK);
      if (i % HZ == off) bus.MODE = 2'(seg_mode[i / HZ + 1]);
    end
    if (end_reset) begin
      #1 RESET = 1'b1;
      #1 chk("async_reset_pulse", int'(bus.PULSE), 0);
      chk("async_reset_elapsed", int'(bus.ELAPSED_SEC), 0);
      bus.START = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
    end else begin
      bus.START = 1'b0;
      bus.MODE  = 2'($urandom_range(0, 3));
      @(negedge CLK);
      check_cleared();
    end
    repeat ($urandom_range(2, 6)) @(negedge CLK);
  endtask

  task automatic set_modes(input int m0, input int m1);
    seg_mode[0] = m0;
    for (int i = 1; i < 16; i++) seg_mode[i] = m1;
  endtask

  initial begin
    bus.START = 1'b1;
    bus.MODE  = 2'b00;
    repeat (3) @(negedge CLK);
    check_cleared();
    RESET = 1'b0;

    set_modes(0, 0);
    run_segment(1, 0, 0, 0);

    set_modes(2, 2);
    run_segment(3, 0, 0, 0);

    set_modes(3, 3);
    run_segment(11, 0, 0, 0);

    set_modes(0, 1);
    run_segment(2, 0, 500, 0);

    set_modes(0, 0);
    run_segment(0, 700, 0, 0);
    run_segment(1, 0, 0, 0);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) seg_mode[i] = int'($urandom_range(0, 3));
      run_segment(int'($urandom_range(0, 2)), int'($urandom_range(1, HZ - 1)), 0, 0);
    end

    set_modes(0, 0);
    run_segment(0, 33, 0, 1);

    repeat (5) @(negedge CLK);
    chk("stb_queue_empty", stb_q.size(), 0);
    chk("tick_queue_empty", tick_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Step-pulse source driving the fitbit step counter's `pulse` input. It emits one pulse per simulated step at a rate chosen by `MODE`: walk, jog, run, or a scripted hybrid profile. It sits between the board's START/MODE switches and the fitbit tracker. Rates are exact per second: a phase accumulator is restarted at every one-second boundary.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second.
- `PULSE_W`, default 4: cycles `PULSE` stays high per step. Must satisfy PULSE_W < CLK_HZ/256.
- `CLK`  input  1  system clock; one clock domain only.
- `RESET`  input  1  asynchronous, active-high reset.
- `START`  input  1  level enable. High runs the generator; low holds it idle.
- `MODE`  input  2  00 walk (32 steps/s), 01 jog (64), 10 run (128), 11 hybrid.
- `PULSE`  output  1  step pulse to the tracker.
- `STEP_STB`  output  1  one-cycle strobe per step; leads `PULSE` by one cycle.
- `SEC_TICK`  output  1  one-cycle strobe on the last cycle of each second.
- `ELAPSED_SEC`  output  16  completed seconds since START rose; saturates at 65535.
- `RATE`  output  8  steps/s in force for the current second.

## Operation
- Reset: every output goes to 0 and all internal counters clear.
- START low: synchronous clear of the accumulator, second counter, `ELAPSED_SEC`, `RATE`, `PULSE` and strobes. MODE is ignored while START is low.
- Second start:
  - The first enabled cycle after START rises begins second 0.
  - `RATE` is loaded from MODE on that cycle.
  - `RATE` is reloaded on the cycle after each `SEC_TICK`.
- MODE changes mid-second take effect at the next second boundary only.
- Accumulator, on each enabled cycle:
  - sum = acc + RATE.
  - If sum >= CLK_HZ: assert `STEP_STB` and set acc = sum - CLK_HZ.
  - Otherwise acc = sum.
- Second counter:
  - Counts 0..CLK_HZ-1.
  - At CLK_HZ-1: `SEC_TICK` = 1, counter wraps, acc forced to 0, `ELAPSED_SEC` increments (saturating).
- Consequence: exactly RATE steps per second. The last step lands on the `SEC_TICK` cycle. Step spacing is floor or ceil of CLK_HZ/RATE.
- Pulse shaper:
  - `STEP_STB` loads a down-counter with PULSE_W.
  - `PULSE` is high while the counter is nonzero.
  - The parameter constraint guarantees `PULSE` returns low between steps.
- Hybrid schedule (MODE 11), indexed by `ELAPSED_SEC` at load time:
  - Seconds 0..8 use rates 20, 33, 66, 27, 70, 30, 19, 30, 33.
  - Second 9 onward uses 69.
- States: IDLE (START low) and RUN. IDLE→RUN when START is high. RUN→IDLE when START is low, taking effect the same edge with no partial second retained.

## Timing
- STEP_STB→PULSE latency: 1 cycle.
- `PULSE` is high for exactly PULSE_W cycles.
- The first step comes on the ceil(CLK_HZ/RATE)-th enabled cycle of a second.
- `SEC_TICK` and a `STEP_STB` coincide on the final cycle of every second with RATE > 0.
- RESET asserted mid-pulse drops `PULSE` immediately (asynchronous). Release restarts in IDLE.
- START dropping mid-pulse clears `PULSE` on the next edge.
- Accumulator width: clog2(CLK_HZ+128)+1 bits, which holds the sum without overflow.
- `ELAPSED_SEC` holds at 65535. The hybrid rate stays 69 there.

## Configuration
- `STEP_PULSE_GEN_HYBRID_EN` defined: MODE 11 follows the hybrid schedule.
- Not defined: MODE 11 loads RATE = 0, so no steps occur. `SEC_TICK` and `ELAPSED_SEC` still run. The schedule ROM is not synthesized.

## Structure
- Package `step_gen_pkg` holds:
  - MODE encodings.
  - WALK/JOG/RUN rate constants.
  - Hybrid table length, entries and tail rate (69).
  - The rate-lookup function `mode_rate(mode, sec)`.
- Sub-module `rate_accumulator` holds the accumulator, compare/subtract, second-boundary clear and `STEP_STB`. The top adds the second counter, mode latch and pulse shaper.

## Test plan
All scenarios use CLK_HZ=1024, PULSE_W=2.
- Reset with START=1, MODE=00, then release → STEP_STB on enabled cycles 32, 64, …, 1024. That is 32 strobes per second. PULSE is high 2 cycles after each strobe. SEC_TICK fires on cycle 1024.
- MODE=10 for 3 s → 128 strobes per second, 384 total. ELAPSED_SEC=3. PULSE is never high for more than 2 consecutive cycles.
- MODE=11 for 11 s with hybrid enabled → per-second counts 20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 69. RATE matches each second.
- MODE 00→01 switched at cycle 500 of a second → that second completes with 32 steps; the next second has 64.
- START dropped at cycle 700 then re-raised → outputs clear on the next edge. ELAPSED_SEC=0. The first step comes 32 cycles after restart (MODE=00).
- Build without `STEP_PULSE_GEN_HYBRID_EN`, MODE=11 → zero strobes. RATE=0. SEC_TICK still every 1024 cycles.
